// File: rtl/resp_demux_1x2.sv
// Response demultiplexer: routes slave response beats to one of two masters
// in the order grants were issued, tracked by a small order FIFO.
module resp_demux_1x2 #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,

    input  logic             grant_valid,
    input  logic             grant_sel,
    output logic             grant_ready,

    input  logic             s_valid,
    input  logic [WIDTH:0]   s_data,
    input  logic             s_last,
    output logic             s_ready,

    output logic             m1_valid,
    output logic [WIDTH:0]   m1_data,
    output logic             m1_last,
    input  logic             m1_ready,

    output logic             m2_valid,
    output logic [WIDTH:0]   m2_data,
    output logic             m2_last,
    input  logic             m2_ready,

    input  logic             enable,
    output logic [$clog2(DEPTH):0] order_count
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cnt_t          count;
    logic          order_mem [DEPTH];

    logic          out_valid;
    logic [WIDTH:0] out_data;
    logic          out_last;
    logic          out_dest;

    logic          push;
    logic          pop;
    logic          accept;
    logic          dest_ready;
    logic          head_sel;

    assign grant_ready = (count < DEPTH_CNT);
    assign push        = grant_valid && grant_ready;
    assign head_sel    = order_mem[rd_ptr];

    assign dest_ready  = out_dest ? m2_ready : m1_ready;
    assign s_ready     = enable && (count != '0) && (!out_valid || dest_ready);
    assign accept      = s_valid && s_ready;
    assign pop         = accept && s_last;

    assign order_count = count;

    // Order FIFO storage needs no reset: pointers and count define validity.
    always_ff @(posedge ACLK) begin
        if (push) begin
            order_mem[wr_ptr] <= grant_sel;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A load in the same cycle as a drain keeps out_valid high for full throughput.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_dest  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= s_data;
            out_last  <= s_last;
            out_dest  <= head_sel;
        end else if (out_valid && dest_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_comb begin
        m1_valid = out_valid && !out_dest;
        m2_valid = out_valid &&  out_dest;
        m1_data  = m1_valid ? out_data : '0;
        m1_last  = m1_valid ? out_last : 1'b0;
        m2_data  = m2_valid ? out_data : '0;
        m2_last  = m2_valid ? out_last : 1'b0;
    end

endmodule

// File: tb/tb_resp_demux_1x2.sv
// Directed, table-driven bench for resp_demux_1x2 with hand sequences for
// FIFO-full, no-bypass and mid-burst reset behaviour.
module tb_resp_demux_1x2;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        grant_valid, grant_sel, grant_ready;
    logic        s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic        m1_valid, m1_last, m1_ready;
    logic [31:0] m1_data;
    logic        m2_valid, m2_last, m2_ready;
    logic [31:0] m2_data;
    logic        enable;
    logic [2:0]  order_count;

    int n_cmp = 0;
    int n_bad = 0;

    resp_demux_1x2 #(.WIDTH(31), .DEPTH(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .grant_valid(grant_valid), .grant_sel(grant_sel), .grant_ready(grant_ready),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m1_valid(m1_valid), .m1_data(m1_data), .m1_last(m1_last), .m1_ready(m1_ready),
        .m2_valid(m2_valid), .m2_data(m2_data), .m2_last(m2_last), .m2_ready(m2_ready),
        .enable(enable), .order_count(order_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        gv, gs, sv;
        logic [31:0] sd;
        logic        sl, r1, r2, en;
        logic        x_sr, x_gr;
        logic        x_m1v;
        logic [31:0] x_m1d;
        logic        x_m1l;
        logic        x_m2v;
        logic [31:0] x_m2d;
        logic        x_m2l;
        logic [2:0]  x_cnt;
    } vec_t;

    function automatic vec_t mk(logic gv, logic gs, logic sv, logic [31:0] sd,
                                logic sl, logic r1, logic r2, logic en,
                                logic xsr, logic xgr,
                                logic xm1v, logic [31:0] xm1d, logic xm1l,
                                logic xm2v, logic [31:0] xm2d, logic xm2l,
                                logic [2:0] xcnt);
        vec_t v;
        v.gv = gv; v.gs = gs; v.sv = sv; v.sd = sd; v.sl = sl;
        v.r1 = r1; v.r2 = r2; v.en = en;
        v.x_sr = xsr; v.x_gr = xgr;
        v.x_m1v = xm1v; v.x_m1d = xm1d; v.x_m1l = xm1l;
        v.x_m2v = xm2v; v.x_m2d = xm2d; v.x_m2l = xm2l;
        v.x_cnt = xcnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic m1v, input logic [31:0] m1d,
                              input logic m1l, input logic m2v, input logic [31:0] m2d,
                              input logic m2l, input logic [2:0] cnt);
        check({tag, " m1_valid"}, 32'(m1_valid), 32'(m1v));
        check({tag, " m1_data"},  m1_data, m1d);
        check({tag, " m1_last"},  32'(m1_last), 32'(m1l));
        check({tag, " m2_valid"}, 32'(m2_valid), 32'(m2v));
        check({tag, " m2_data"},  m2_data, m2d);
        check({tag, " m2_last"},  32'(m2_last), 32'(m2l));
        check({tag, " order_count"}, 32'(order_count), 32'(cnt));
    endtask

    // Inputs change at posedge+1; ready/grant_ready sampled after settling,
    // registered outputs sampled 1 time unit after the following edge.
    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        grant_valid = v.gv; grant_sel = v.gs;
        s_valid = v.sv; s_data = v.sd; s_last = v.sl;
        m1_ready = v.r1; m2_ready = v.r2; enable = v.en;
        #1;
        check({tag, " s_ready"},     32'(s_ready),     32'(v.x_sr));
        check({tag, " grant_ready"}, 32'(grant_ready), 32'(v.x_gr));
        @(posedge ACLK); #1;
        check_outs(tag, v.x_m1v, v.x_m1d, v.x_m1l, v.x_m2v, v.x_m2d, v.x_m2l, v.x_cnt);
    endtask

    task automatic tick;
        @(posedge ACLK); #1;
    endtask

    vec_t vecs [19];

    initial begin
        vecs[0]  = mk(1,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd1);
        vecs[1]  = mk(0,0,1,32'h12345678,1,1,1,1, 1,1, 1,32'h12345678,1, 0,32'h0,0,        3'd0);
        vecs[2]  = mk(0,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd0);
        vecs[3]  = mk(1,1,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd1);
        vecs[4]  = mk(1,0,1,32'hAAAAAAAA,0,1,1,1, 1,1, 0,32'h0,0,        1,32'hAAAAAAAA,0, 3'd2);
        vecs[5]  = mk(0,0,1,32'hBBBBBBBB,0,1,1,1, 1,1, 0,32'h0,0,        1,32'hBBBBBBBB,0, 3'd2);
        vecs[6]  = mk(0,0,1,32'hCCCCCCCC,1,1,1,1, 1,1, 0,32'h0,0,        1,32'hCCCCCCCC,1, 3'd1);
        vecs[7]  = mk(0,0,1,32'h11111111,1,1,1,1, 1,1, 1,32'h11111111,1, 0,32'h0,0,        3'd0);
        vecs[8]  = mk(0,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd0);
        vecs[9]  = mk(1,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd1);
        vecs[10] = mk(0,0,1,32'h22222222,0,0,1,1, 1,1, 1,32'h22222222,0, 0,32'h0,0,        3'd1);
        vecs[11] = mk(0,0,1,32'h33333333,1,0,1,1, 0,1, 1,32'h22222222,0, 0,32'h0,0,        3'd1);
        vecs[12] = mk(0,0,1,32'h33333333,1,0,1,0, 0,1, 1,32'h22222222,0, 0,32'h0,0,        3'd1);
        vecs[13] = mk(0,0,1,32'h33333333,1,1,1,0, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd1);
        vecs[14] = mk(0,0,1,32'h33333333,1,1,1,0, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd1);
        vecs[15] = mk(0,0,1,32'h33333333,1,1,1,1, 1,1, 1,32'h33333333,1, 0,32'h0,0,        3'd0);
        vecs[16] = mk(0,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd0);
        vecs[17] = mk(0,0,1,32'h44444444,1,1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd0);
        vecs[18] = mk(0,0,0,32'h0,0,       1,1,1, 0,1, 0,32'h0,0,        0,32'h0,0,        3'd0);

        ARESETN = 1'b0;
        grant_valid = 0; grant_sel = 0; s_valid = 0; s_data = '0; s_last = 0;
        m1_ready = 1; m2_ready = 1; enable = 1;
        repeat (2) @(posedge ACLK);
        #1;
        check("reset s_ready", 32'(s_ready), 32'd0);
        check("reset grant_ready", 32'(grant_ready), 32'd1);
        check_outs("reset", 0, 32'h0, 0, 0, 32'h0, 0, 3'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            apply_vec(vecs[i], i);
        end

        // Fill the order FIFO: grants 1,0,1,0.
        for (int i = 0; i < 4; i++) begin
            grant_valid = 1; grant_sel = (i % 2 == 0);
            tick();
        end
        grant_valid = 0;
        #1;
        check("full grant_ready", 32'(grant_ready), 32'd0);
        check("full order_count", 32'(order_count), 32'd4);
        grant_valid = 1; grant_sel = 1;
        tick();
        check("ignored grant count", 32'(order_count), 32'd4);

        // Pop while full with a grant offered: the grant must not sneak in.
        grant_valid = 1; grant_sel = 0;
        s_valid = 1; s_data = 32'h55555555; s_last = 1;
        #1;
        check("pop-when-full s_ready", 32'(s_ready), 32'd1);
        check("pop-when-full grant_ready", 32'(grant_ready), 32'd0);
        tick();
        grant_valid = 0;
        #1;
        check("after pop grant_ready", 32'(grant_ready), 32'd1);
        check_outs("after pop", 0, 32'h0, 0, 1, 32'h55555555, 1, 3'd3);

        // Non-last beat held on m1, then reset mid-burst.
        s_valid = 1; s_data = 32'h66666666; s_last = 0;
        tick();
        check_outs("mid-burst", 1, 32'h66666666, 0, 0, 32'h0, 0, 3'd3);
        #2;
        ARESETN = 1'b0;
        #1;
        check("async reset s_ready", 32'(s_ready), 32'd0);
        check("async reset grant_ready", 32'(grant_ready), 32'd1);
        check_outs("async reset", 0, 32'h0, 0, 0, 32'h0, 0, 3'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();

        // First post-reset grant routes to m2; no same-cycle bypass.
        grant_valid = 1; grant_sel = 1;
        s_valid = 1; s_data = 32'h77777777; s_last = 1;
        #1;
        check("no bypass s_ready", 32'(s_ready), 32'd0);
        tick();
        check_outs("post-reset push", 0, 32'h0, 0, 0, 32'h0, 0, 3'd1);
        grant_valid = 0;
        #1;
        check("post-reset s_ready", 32'(s_ready), 32'd1);
        tick();
        check_outs("post-reset beat", 0, 32'h0, 0, 1, 32'h77777777, 1, 3'd0);
        s_valid = 0;
        tick();
        check_outs("final drain", 0, 32'h0, 0, 0, 32'h0, 0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
